// File: rtl/m_memarb.sv
// Two-port (instruction fetch / data) arbiter in front of one single-port synchronous RAM.
// D has priority with a starvation cap for I; every access is grant -> issue -> response.
module m_memarb #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_halt,
  input  logic          w_i_req,
  input  logic [AW-1:0] w_i_addr,
  input  logic          w_d_req,
  input  logic          w_d_we,
  input  logic [AW-1:0] w_d_addr,
  input  logic [DW-1:0] w_d_wdata,
  output logic          r_i_done,
  output logic [DW-1:0] r_i_rdata,
  output logic          r_d_done,
  output logic [DW-1:0] r_d_rdata,
  output logic [AW-1:0] r_maddr,
  output logic          r_mwe,
  output logic [DW-1:0] r_mdin,
  input  logic [DW-1:0] w_mdout,
  output logic [15:0]   r_conflict
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_I,
    S_ISSUE_D,
    S_RESP_I,
    S_RESP_D
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_starve;
  logic          r_i_mask;
  logic          r_d_mask;
  logic          w_i_elig;
  logic          w_d_elig;
  logic          w_starved;
  logic          w_grant_i;
  logic          w_grant_d;

  // State register
  always_ff @(posedge w_clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and grant decision
  always_comb begin
    w_i_elig  = w_i_req & ~w_halt & ~r_i_mask;
    w_d_elig  = w_d_req & ~w_halt & ~r_d_mask;
    w_starved = (r_starve == SW'(STARVE_MAX));
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_next    = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_d_elig && !(w_i_elig && w_starved)) begin
          w_grant_d = 1'b1;
          w_next    = S_ISSUE_D;
        end else if (w_i_elig) begin
          w_grant_i = 1'b1;
          w_next    = S_ISSUE_I;
        end
      end
      S_ISSUE_I: w_next = S_RESP_I;
      S_ISSUE_D: w_next = S_RESP_D;
      S_RESP_I:  w_next = S_IDLE;
      S_RESP_D:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Registered outputs and bookkeeping
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_maddr    <= '0;
      r_mwe      <= 1'b0;
      r_mdin     <= '0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_conflict <= '0;
      r_starve   <= '0;
      r_i_mask   <= 1'b0;
      r_d_mask   <= 1'b0;
    end else begin
      // Mask is the done pulse delayed a cycle, so it only bites if IDLE lingers after RESP.
      r_i_mask <= r_i_done;
      r_d_mask <= r_d_done;
      r_i_done <= (r_state == S_RESP_I);
      r_d_done <= (r_state == S_RESP_D);
      if (r_state == S_RESP_I) r_i_rdata <= w_mdout;
      if (r_state == S_RESP_D) r_d_rdata <= w_mdout;
      r_mwe <= w_grant_d & w_d_we;
      if (w_grant_i) begin
        r_maddr  <= w_i_addr;
        r_mdin   <= w_d_wdata;
        r_starve <= '0;
      end else if (w_grant_d) begin
        r_maddr <= w_d_addr;
        r_mdin  <= w_d_wdata;
        if (!w_i_req)        r_starve <= '0;
        else if (!w_starved) r_starve <= r_starve + 1'b1;
      end
      if (w_i_req && w_d_req && (r_conflict != '1)) r_conflict <= r_conflict + 16'd1;
    end
  end

endmodule

// File: tb/tb_m_memarb.sv
// Self-checking bench for m_memarb: table of single transactions against a read-first RAM model,
// plus hand sequences for contention, halt and reset during a write.
module tb_m_memarb;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, halt;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_done, d_done;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] maddr;
  logic          mwe;
  logic [DW-1:0] mdin, mdout;
  logic [15:0]   conflict;

  always #5 clk = ~clk;

  m_memarb #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
    .w_clk(clk), .w_rst(rst), .w_halt(halt),
    .w_i_req(i_req), .w_i_addr(i_addr),
    .w_d_req(d_req), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_wdata(d_wdata),
    .r_i_done(i_done), .r_i_rdata(i_rdata),
    .r_d_done(d_done), .r_d_rdata(d_rdata),
    .r_maddr(maddr), .r_mwe(mwe), .r_mdin(mdin),
    .w_mdout(mdout), .r_conflict(conflict)
  );

  // Read-first single-port RAM; preload pattern is word = 0x1000_0000 + addr, except word 5.
  logic [DW-1:0] ram [0:4095];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++)
        ram[i] <= (i == 5) ? 32'h0000_1234 : 32'h1000_0000 + 32'(i);
      mdout <= '0;
    end else begin
      mdout <= ram[maddr];
      if (mwe) ram[maddr] <= mdin;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit            port_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    int mwe_cnt;
    int wrong;
    bit got;
    logic [DW-1:0] rd;
    if (v.port_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    lat = 0; mwe_cnt = 0; wrong = 0; got = 1'b0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (mwe) mwe_cnt++;
      if (v.port_d ? i_done : d_done) wrong++;
      got = v.port_d ? d_done : i_done;
    end
    rd = v.port_d ? d_rdata : i_rdata;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, v.exp);
    chk({tag, "_mwe_cycles"}, 32'(mwe_cnt), v.we ? 32'd1 : 32'd0);
    chk({tag, "_other_done"}, 32'(wrong), 32'd0);
    tick();
    tick();
    chk({tag, "_rdata_hold"}, v.port_d ? d_rdata : i_rdata, v.exp);
  endtask

  vec_t vecs [10];
  vec_t v;
  logic [7:0] order;
  int ndone;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 12'd5,    32'h0,         32'h0000_1234};
    vecs[1] = '{1'b1, 1'b1, 12'd7,    32'h0000_CAFE, 32'h1000_0007};
    vecs[2] = '{1'b1, 1'b0, 12'd7,    32'h0,         32'h0000_CAFE};
    vecs[3] = '{1'b0, 1'b0, 12'd7,    32'h0,         32'h0000_CAFE};
    vecs[4] = '{1'b1, 1'b1, 12'd0,    32'hDEAD_BEEF, 32'h1000_0000};
    vecs[5] = '{1'b0, 1'b0, 12'd0,    32'h0,         32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 1'b0, 12'd4095, 32'h0,         32'h1000_0FFF};
    vecs[7] = '{1'b1, 1'b1, 12'd4095, 32'hFFFF_FFFF, 32'h1000_0FFF};
    vecs[8] = '{1'b0, 1'b0, 12'd4095, 32'h0,         32'hFFFF_FFFF};
    vecs[9] = '{1'b1, 1'b0, 12'd5,    32'h0,         32'h0000_1234};

    // Reset dominates even with both requests high.
    preload = 1'b1; rst = 1'b1; halt = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 12'd3; d_addr = 12'd4; d_wdata = 32'hAAAA_5555;
    tick(); tick();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    preload = 1'b0; rst = 1'b0;
    chk("rst_i_done",   32'(i_done),         32'd0);
    chk("rst_d_done",   32'(d_done),         32'd0);
    chk("rst_i_rdata",  i_rdata,             32'd0);
    chk("rst_d_rdata",  d_rdata,             32'd0);
    chk("rst_maddr",    32'(maddr),          32'd0);
    chk("rst_mwe",      32'(mwe),            32'd0);
    chk("rst_mdin",     mdin,                32'd0);
    chk("rst_conflict", {16'h0, conflict},   32'd0);

    for (int k = 0; k < 10; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // Contention: both held high, expect D,D,D,I,D,D,D,I and conflict +1 per cycle.
    do_rst();
    i_addr = 12'd1; d_addr = 12'd2; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    order = '0; ndone = 0;
    for (int t = 1; t <= 24; t++) begin
      tick();
      chk($sformatf("contend_conflict_t%0d", t), {16'h0, conflict}, 32'(t));
      if (d_done) begin order = {order[6:0], 1'b1}; ndone++; end
      if (i_done) begin order = {order[6:0], 1'b0}; ndone++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("contend_ndone", 32'(ndone), 32'd8);
    chk("contend_order", {24'h0, order}, {24'h0, 8'b1110_1110});
    chk("contend_i_rdata", i_rdata, 32'h1000_0001);
    chk("contend_d_rdata", d_rdata, 32'h1000_0002);

    // Halt raised during ISSUE_I: I finishes, nothing granted until release.
    do_rst();
    i_addr = 12'd3; i_req = 1'b1;
    tick();
    halt = 1'b1; d_req = 1'b1; d_addr = 12'd4; d_we = 1'b0;
    tick();
    chk("halt_i_done_early", 32'(i_done), 32'd0);
    tick();
    chk("halt_i_done", 32'(i_done), 32'd1);
    chk("halt_i_rdata", i_rdata, 32'h1000_0003);
    i_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("halt_hold_maddr%0d", k), 32'(maddr), 32'd3);
      chk($sformatf("halt_hold_d_done%0d", k), 32'(d_done), 32'd0);
    end
    halt = 1'b0;
    tick();
    chk("halt_release_maddr", 32'(maddr), 32'd4);
    tick();
    tick();
    chk("halt_release_d_done", 32'(d_done), 32'd1);
    chk("halt_release_d_rdata", d_rdata, 32'h1000_0004);
    d_req = 1'b0;
    tick();

    // Reset while a D write is in ISSUE_D.
    do_rst();
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'd9; d_wdata = 32'h0000_55AA;
    tick();
    chk("rstw_mwe_before", 32'(mwe), 32'd1);
    chk("rstw_maddr_before", 32'(maddr), 32'd9);
    rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("rstw_mwe", 32'(mwe), 32'd0);
    chk("rstw_maddr", 32'(maddr), 32'd0);
    chk("rstw_mdin", mdin, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rstw_no_d_done%0d", k), 32'(d_done), 32'd0);
    end
    v = '{1'b0, 1'b0, 12'd10, 32'h0, 32'h1000_000A};
    run_txn(v, "rstw_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
